// File: rtl/mdu_param_if.sv
`default_nettype none
// ============================================================================
// Module      : mdu_param_if
// Description : Request/result bundle between the pipeline and the MDU.
// Revision    : 1.0 - initial release
// ============================================================================
interface mdu_param_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [3:0]       mdu_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             done;

    modport master (
        output start, mdu_op, a, b, abort,
        input  hi, lo, out, busy, done
    );

    modport slave (
        input  start, mdu_op, a, b, abort,
        output hi, lo, out, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/mdu_param.sv
`default_nettype none
// ============================================================================
// Module      : mdu_param
// Description : MIPS-style multiply/divide unit with HI/LO, fixed latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_param #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  wire logic  clk,
    input  wire logic  reset,
    mdu_param_if.slave bus
);
    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT);
    localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    localparam logic [WIDTH-1:0] MIN_INT  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] NEG_ONE  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [3:0]       op_q,    op_d;
    logic [WIDTH-1:0] a_q,     a_d;
    logic [WIDTH-1:0] b_q,     b_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;
    logic             done_q,  done_d;

    // Product datapath: the low 2*WIDTH bits of the sign-extended product
    // are exactly the signed 2*WIDTH-bit result.
    logic signed [2*WIDTH-1:0] w_a_sx, w_b_sx, w_prod_s;
    logic        [2*WIDTH-1:0] w_prod_u;

    assign w_a_sx   = {{WIDTH{a_q[WIDTH-1]}}, a_q};
    assign w_b_sx   = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign w_prod_s = w_a_sx * w_b_sx;
    assign w_prod_u = {ZERO_W, a_q} * {ZERO_W, b_q};

    // MIN_INT / -1 is steered to MIN_INT / 1, which yields exactly the
    // architected LO=MIN_INT, HI=0 without overflowing the divider.
    logic                    w_div_zero, w_div_ovf;
    logic signed [WIDTH-1:0] w_a_sgn, w_b_sgn_safe, w_quo_s, w_rem_s;
    logic        [WIDTH-1:0] w_b_uns_safe, w_quo_u, w_rem_u;

    assign w_div_zero   = (b_q == ZERO_W);
    assign w_div_ovf    = (a_q == MIN_INT) && (b_q == NEG_ONE);
    assign w_a_sgn      = a_q;
    assign w_b_sgn_safe = (w_div_zero || w_div_ovf) ? ONE_W : b_q;
    assign w_b_uns_safe = w_div_zero ? ONE_W : b_q;
    assign w_quo_s      = w_a_sgn / w_b_sgn_safe;
    assign w_rem_s      = w_a_sgn % w_b_sgn_safe;
    assign w_quo_u      = a_q / w_b_uns_safe;
    assign w_rem_u      = a_q % w_b_uns_safe;

    logic w_is_long_op;
    assign w_is_long_op = (bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU) ||
                          (bus.mdu_op == OP_DIV)  || (bus.mdu_op == OP_DIVU);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!bus.abort) begin
                    if (bus.start) begin
                        if (w_is_long_op) begin
                            op_d    = bus.mdu_op;
                            a_d     = bus.a;
                            b_d     = bus.b;
                            cnt_d   = ((bus.mdu_op == OP_MULT) || (bus.mdu_op == OP_MULTU))
                                      ? MUL_CNT : DIV_CNT;
                            state_d = ST_RUN;
                        end
                    end else if (bus.mdu_op == OP_MTHI) begin
                        hi_d = bus.a;
                    end else if (bus.mdu_op == OP_MTLO) begin
                        lo_d = bus.a;
                    end
                end
            end

            ST_RUN: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_ONE) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_MULT:  {hi_d, lo_d} = w_prod_s;
                        OP_MULTU: {hi_d, lo_d} = w_prod_u;
                        OP_DIV: begin
                            if (!w_div_zero) begin
                                lo_d = w_quo_s;
                                hi_d = w_rem_s;
                            end
                        end
                        OP_DIVU: begin
                            if (!w_div_zero) begin
                                lo_d = w_quo_u;
                                hi_d = w_rem_u;
                            end
                        end
                        default: ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
    assign bus.busy = (state_q == ST_RUN);
    assign bus.done = done_q;
    assign bus.out  = (bus.mdu_op == OP_MFHI) ? hi_q :
                      (bus.mdu_op == OP_MFLO) ? lo_q : ZERO_W;

endmodule
`default_nettype wire

// File: tb/tb_mdu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_mdu_param
// Description : Directed + random bench for mdu_param (32/5/10 and 16/1/1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mdu_param;
    logic clk = 1'b0;
    logic reset;
    logic reset16;

    always #5 clk = ~clk;

    mdu_param_if #(.WIDTH(32)) bus   ();
    mdu_param_if #(.WIDTH(16)) bus16 ();

    mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    mdu_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(1)) dut16 (
        .clk   (clk),
        .reset (reset16),
        .bus   (bus16.slave)
    );

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi, m_lo;
    logic [31:0] m16_hi, m16_lo;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Architectural reference: full-precision arithmetic on 64-bit values,
    // then truncated to w bits.
    task automatic ref_op(input int w, input logic [3:0] op, input logic [31:0] a, b,
                          inout logic [31:0] h, inout logic [31:0] l);
        logic [63:0]        mask, ua, ub, up;
        logic signed [63:0] sa, sb, sp;
        mask = (64'd1 << w) - 64'd1;
        ua   = {32'd0, a} & mask;
        ub   = {32'd0, b} & mask;
        sa   = $signed(ua << (64 - w)) >>> (64 - w);
        sb   = $signed(ub << (64 - w)) >>> (64 - w);
        case (op)
            OP_MULT: begin
                sp = sa * sb;
                h  = 32'((sp >> w) & mask);
                l  = 32'(sp & mask);
            end
            OP_MULTU: begin
                up = ua * ub;
                h  = 32'((up >> w) & mask);
                l  = 32'(up & mask);
            end
            OP_DIV: if (sb != 0) begin
                sp = sa / sb;
                l  = 32'(sp & mask);
                sp = sa % sb;
                h  = 32'(sp & mask);
            end
            OP_DIVU: if (ub != 0) begin
                l = 32'((ua / ub) & mask);
                h = 32'((ua % ub) & mask);
            end
            OP_MTHI: h = 32'(ua);
            OP_MTLO: l = 32'(ua);
            default: ;
        endcase
    endtask

    // Issues one multi-cycle op on the 32-bit unit and checks the whole
    // busy window and the result cycle. Optionally pokes a start while busy
    // or raises abort in the done cycle.
    task automatic run32(input logic [3:0] op, input logic [31:0] a, b,
                         input bit disturb, input bit abort_on_done, input string tag);
        int lat;
        lat = (op == OP_MULT || op == OP_MULTU) ? 5 : 10;
        bus.start  = 1'b1;
        bus.mdu_op = op;
        bus.a      = a;
        bus.b      = b;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.mdu_op = 4'd0;
        for (int i = 0; i < lat; i++) begin
            chk($sformatf("%s busy[%0d]", tag, i), 64'(bus.busy), 64'd1);
            chk($sformatf("%s done[%0d]", tag, i), 64'(bus.done), 64'd0);
            if (disturb && i == 1) begin
                bus.start  = 1'b1;
                bus.mdu_op = OP_DIVU;
                bus.a      = $urandom;
                bus.b      = 32'd3;
            end else begin
                bus.start  = 1'b0;
                bus.mdu_op = 4'd0;
            end
            @(negedge clk);
        end
        ref_op(32, op, a, b, m_hi, m_lo);
        chk({tag, " busy_end"}, 64'(bus.busy), 64'd0);
        chk({tag, " done"},     64'(bus.done), 64'd1);
        chk({tag, " hi"},       64'(bus.hi),   64'(m_hi));
        chk({tag, " lo"},       64'(bus.lo),   64'(m_lo));
        if (abort_on_done) bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk({tag, " done_off"}, 64'(bus.done), 64'd0);
        chk({tag, " busy_off"}, 64'(bus.busy), 64'd0);
        if (abort_on_done) begin
            chk({tag, " hi_kept"}, 64'(bus.hi), 64'(m_hi));
            chk({tag, " lo_kept"}, 64'(bus.lo), 64'(m_lo));
        end
    endtask

    task automatic move32(input logic [3:0] op, input logic [31:0] a, input string tag);
        bus.mdu_op = op;
        bus.a      = a;
        @(negedge clk);
        bus.mdu_op = 4'd0;
        ref_op(32, op, a, 32'd0, m_hi, m_lo);
        chk({tag, " hi"}, 64'(bus.hi), 64'(m_hi));
        chk({tag, " lo"}, 64'(bus.lo), 64'(m_lo));
    endtask

    task automatic check_out32(input string tag);
        bus.mdu_op = OP_MFHI;
        #1 chk({tag, " mfhi"}, 64'(bus.out), 64'(m_hi));
        bus.mdu_op = OP_MFLO;
        #1 chk({tag, " mflo"}, 64'(bus.out), 64'(m_lo));
        bus.mdu_op = 4'd11;
        #1 chk({tag, " out_other"}, 64'(bus.out), 64'd0);
        bus.mdu_op = 4'd0;
    endtask

    task automatic run16(input logic [3:0] op, input logic [15:0] a, b, input string tag);
        bus16.start  = 1'b1;
        bus16.mdu_op = op;
        bus16.a      = a;
        bus16.b      = b;
        @(negedge clk);
        bus16.start  = 1'b0;
        bus16.mdu_op = 4'd0;
        chk({tag, " busy"}, 64'(bus16.busy), 64'd1);
        chk({tag, " done0"}, 64'(bus16.done), 64'd0);
        @(negedge clk);
        ref_op(16, op, {16'd0, a}, {16'd0, b}, m16_hi, m16_lo);
        chk({tag, " busy_end"}, 64'(bus16.busy), 64'd0);
        chk({tag, " done"},     64'(bus16.done), 64'd1);
        chk({tag, " hi"},       64'(bus16.hi),   64'(m16_hi));
        chk({tag, " lo"},       64'(bus16.lo),   64'(m16_lo));
        @(negedge clk);
        chk({tag, " done_off"}, 64'(bus16.done), 64'd0);
    endtask

    initial begin
        logic [3:0]  r_op;
        logic [31:0] r_a, r_b;
        int          sel;

        reset        = 1'b1;
        reset16      = 1'b1;
        bus.start    = 1'b0;  bus.mdu_op   = 4'd0;  bus.a   = '0;  bus.b   = '0;  bus.abort   = 1'b0;
        bus16.start  = 1'b0;  bus16.mdu_op = 4'd0;  bus16.a = '0;  bus16.b = '0;  bus16.abort = 1'b0;
        m_hi = '0; m_lo = '0; m16_hi = '0; m16_lo = '0;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        reset16 = 1'b0;

        chk("rst hi",   64'(bus.hi),   64'd0);
        chk("rst lo",   64'(bus.lo),   64'd0);
        chk("rst busy", 64'(bus.busy), 64'd0);
        chk("rst done", 64'(bus.done), 64'd0);

        run32(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0, "mult_neg3x5");
        run32(OP_DIV,  32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg7by2");
        run32(OP_DIVU, 32'd7,         32'd2, 1'b0, 1'b0, "divu_7by2");

        move32(OP_MTHI, 32'h0000_1234, "mthi");
        check_out32("after_mthi");
        run32(OP_DIV, 32'd99, 32'd0, 1'b0, 1'b0, "div_by_zero");

        // Ignored start codes: nothing should move.
        bus.start = 1'b1; bus.mdu_op = OP_MFLO;
        @(negedge clk);
        bus.start = 1'b0; bus.mdu_op = 4'd0;
        chk("ign_start busy", 64'(bus.busy), 64'd0);

        // Abort on the 3rd busy cycle; mtlo offered while busy is dropped.
        bus.start = 1'b1; bus.mdu_op = OP_MULTU; bus.a = '1; bus.b = '1;
        @(negedge clk);
        bus.start = 1'b0; bus.mdu_op = OP_MTLO; bus.a = 32'd7;
        @(negedge clk);
        bus.mdu_op = 4'd0;
        chk("abort lo_not_moved", 64'(bus.lo), 64'(m_lo));
        @(negedge clk);
        chk("abort busy3", 64'(bus.busy), 64'd1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort busy_off", 64'(bus.busy), 64'd0);
        chk("abort no_done",  64'(bus.done), 64'd0);
        chk("abort hi",       64'(bus.hi),   64'(m_hi));
        chk("abort lo",       64'(bus.lo),   64'(m_lo));
        @(negedge clk);
        chk("abort no_done_late", 64'(bus.done), 64'd0);
        move32(OP_MTLO, 32'd7, "mtlo_after_abort");

        // Abort in idle blocks a mthi.
        bus.abort = 1'b1; bus.mdu_op = OP_MTHI; bus.a = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.abort = 1'b0; bus.mdu_op = 4'd0;
        chk("abort_idle hi", 64'(bus.hi), 64'(m_hi));

        run32(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, "div_min_by_m1");
        run32(OP_MULT, 32'd3,         32'd4,         1'b1, 1'b0, "mult_start_busy");

        // Reset on the 2nd busy cycle.
        bus.start = 1'b1; bus.mdu_op = OP_MULT; bus.a = 32'd11; bus.b = 32'd13;
        @(negedge clk);
        bus.start = 1'b0; bus.mdu_op = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = '0; m_lo = '0;
        chk("rst_mid busy", 64'(bus.busy), 64'd0);
        chk("rst_mid done", 64'(bus.done), 64'd0);
        chk("rst_mid hi",   64'(bus.hi),   64'd0);
        chk("rst_mid lo",   64'(bus.lo),   64'd0);
        repeat (6) @(negedge clk);
        chk("rst_mid no_done", 64'(bus.done), 64'd0);

        for (int i = 0; i < 40; i++) begin
            sel  = int'($urandom_range(0, 5));
            r_op = (sel < 4) ? 4'(sel + 1) : 4'(sel + 3);
            r_a  = $urandom;
            r_b  = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'(int'($urandom_range(1, 9)));
                default: ;
            endcase
            if (r_op == OP_MTHI || r_op == OP_MTLO)
                move32(r_op, r_a, $sformatf("rnd%0d_mt", i));
            else
                run32(r_op, r_a, r_b, 1'b0, 1'b0, $sformatf("rnd%0d_op%0d", i, r_op));
            check_out32($sformatf("rnd%0d", i));
        end

        run16(OP_MULT, 16'h8000, 16'hFFFF, "w16_mult");
        run16(OP_DIV,  16'h8000, 16'hFFFF, "w16_div");
        run16(OP_DIVU, 16'hFFFF, 16'h0010, "w16_divu");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
